// File: rtl/alfa_pkg.sv
// alfa_pkg: shared definitions for the note display.
//   - note code constants (NOTA_C .. NOTA_B, NOTA_PAUSA)
//   - seven-segment glyphs {a,b,c,d,e,f,g}, active-high
//   - slot_t: one window slot (occupied flag + tone + note code)
//   - glyph(): maps a slot to {seg, dp}
package alfa_pkg;

   localparam logic [2:0] NOTA_C     = 3'd0;
   localparam logic [2:0] NOTA_D     = 3'd1;
   localparam logic [2:0] NOTA_E     = 3'd2;
   localparam logic [2:0] NOTA_F     = 3'd3;
   localparam logic [2:0] NOTA_G     = 3'd4;
   localparam logic [2:0] NOTA_A     = 3'd5;
   localparam logic [2:0] NOTA_B     = 3'd6;
   localparam logic [2:0] NOTA_PAUSA = 3'd7;

   localparam logic [6:0] SEG_C      = 7'b1001110;
   localparam logic [6:0] SEG_D      = 7'b0111101;
   localparam logic [6:0] SEG_E      = 7'b1001111;
   localparam logic [6:0] SEG_F      = 7'b1000111;
   localparam logic [6:0] SEG_G      = 7'b1111011;
   localparam logic [6:0] SEG_A      = 7'b1110111;
   localparam logic [6:0] SEG_B      = 7'b0011111;
   localparam logic [6:0] SEG_PAUSA  = 7'b0000001;
   localparam logic [6:0] SEG_VAZIO  = 7'b0000000;

   typedef struct packed {
      logic       ocupado;
      logic       tom;
      logic [2:0] notas;
   } slot_t;

   // Returns {seg[6:0], dp}. A rest never lights the sharp dot.
   function automatic logic [7:0] glyph(input logic tom, input logic [2:0] notas,
                                        input logic ocupado);
      logic [6:0] s;
      logic       d;
      s = SEG_VAZIO;
      d = 1'b0;
      if (ocupado) begin
         case (notas)
            NOTA_C:  s = SEG_C;
            NOTA_D:  s = SEG_D;
            NOTA_E:  s = SEG_E;
            NOTA_F:  s = SEG_F;
            NOTA_G:  s = SEG_G;
            NOTA_A:  s = SEG_A;
            NOTA_B:  s = SEG_B;
            default: s = SEG_PAUSA;
         endcase
         d = tom && (notas != NOTA_PAUSA);
      end
      return {s, d};
   endfunction

endpackage

// File: rtl/alfa_fifo.sv
// alfa_fifo: synchronous FIFO with registered full/empty flags.
//   clk, rst_n   clock, async active-low reset
//   clear        synchronous flush (wins over push/pop)
//   push, din    write when !full
//   pop, dout    read head (dout is the current head, valid when !empty)
//   full, empty  registered status flags
//   count        occupancy
module alfa_fifo #(
   parameter int DEPTH = 8,
   parameter int W     = 4
) (
   input  logic                         clk,
   input  logic                         rst_n,
   input  logic                         clear,
   input  logic                         push,
   input  logic [W-1:0]                 din,
   input  logic                         pop,
   output logic [W-1:0]                 dout,
   output logic                         full,
   output logic                         empty,
   output logic [$clog2(DEPTH+1)-1:0]   count
);
   localparam int AW = $clog2(DEPTH);
   localparam int CW = $clog2(DEPTH+1);

   logic [W-1:0]  mem [DEPTH];
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;
   logic          do_push;
   logic          do_pop;
   logic [CW-1:0] count_nxt;

   assign do_push = push && !full && !clear;
   assign do_pop  = pop && !empty && !clear;
   assign dout    = mem[rd_ptr];

   always_comb begin
      count_nxt = count;
      if (clear)
         count_nxt = '0;
      else if (do_push && !do_pop)
         count_nxt = count + CW'(1);
      else if (do_pop && !do_push)
         count_nxt = count - CW'(1);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
         full   <= 1'b0;
         empty  <= 1'b1;
      end else begin
         if (clear) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
         end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
         end
         count <= count_nxt;
         full  <= (count_nxt == CW'(DEPTH));
         empty <= (count_nxt == '0);
      end
   end

   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr] <= din;
   end

endmodule

// File: rtl/alfa_nota_display.sv
// alfa_nota_display: buffers notes from a valid/ready stream, scrolls them
// into an N_DIGITS window at a fixed tempo and scans the window onto a
// multiplexed seven-segment display (dp marks sharps).
//   clk, rst_n              clock, async active-low reset
//   in_valid/in_ready       note handshake; in_tom = sharp, in_notas = code
//   pausa                   freeze scrolling, FIFO keeps accepting
//   limpar                  synchronous clear of FIFO, window, tempo counter
//   seg, dp, digito         registered display drive, active-high
//   nivel                   FIFO occupancy
module alfa_nota_display
   import alfa_pkg::*;
#(
   parameter int N_DIGITS    = 4,
   parameter int DEPTH       = 8,
   parameter int STEP_CYCLES = 50_000_000,
   parameter int SCAN_DIV    = 100_000
) (
   input  logic                         clk,
   input  logic                         rst_n,
   input  logic                         in_valid,
   output logic                         in_ready,
   input  logic                         in_tom,
   input  logic [2:0]                   in_notas,
   input  logic                         pausa,
   input  logic                         limpar,
   output logic [6:0]                   seg,
   output logic                         dp,
   output logic [N_DIGITS-1:0]          digito,
   output logic [$clog2(DEPTH+1)-1:0]   nivel
);
   localparam int SW = $clog2(STEP_CYCLES);
   localparam int DW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
   localparam int PW = $clog2(N_DIGITS);

   logic                 fifo_full;
   logic                 fifo_empty;
   logic [3:0]           fifo_dout;
   logic                 push;
   logic                 pop;
   logic                 tc;

   logic [SW-1:0]        step_cnt;
   logic [DW-1:0]        scan_cnt;
   logic [DW-1:0]        scan_cnt_nxt;
   logic [PW-1:0]        sel;
   logic [PW-1:0]        sel_nxt;
   slot_t [N_DIGITS-1:0] janela;
   slot_t [N_DIGITS-1:0] janela_nxt;
   logic [7:0]           glyph_nxt;

   // full is a flop inside the FIFO, so in_ready stays low for the whole
   // cycle even when a pop frees a slot on the same edge.
   assign in_ready = !fifo_full;
   assign push     = in_valid && !fifo_full && !limpar;
   assign tc       = (step_cnt == SW'(STEP_CYCLES - 1));
   assign pop      = tc && !pausa && !fifo_empty && !limpar;

   alfa_fifo #(
      .DEPTH (DEPTH),
      .W     (4)
   ) u_fifo (
      .clk   (clk),
      .rst_n (rst_n),
      .clear (limpar),
      .push  (push),
      .din   ({in_tom, in_notas}),
      .pop   (pop),
      .dout  (fifo_dout),
      .full  (fifo_full),
      .empty (fifo_empty),
      .count (nivel)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         step_cnt <= '0;
      else if (limpar)
         step_cnt <= '0;
      else if (!pausa)
         step_cnt <= tc ? '0 : step_cnt + SW'(1);
   end

   always_comb begin
      janela_nxt = janela;
      if (limpar) begin
         janela_nxt = '0;
      end else if (pop) begin
         for (int k = N_DIGITS - 1; k > 0; k--)
            janela_nxt[k] = janela[k-1];
         janela_nxt[0] = {1'b1, fifo_dout};
      end
   end

   always_comb begin
      scan_cnt_nxt = scan_cnt + DW'(1);
      sel_nxt      = sel;
      if (scan_cnt == DW'(SCAN_DIV - 1)) begin
         scan_cnt_nxt = '0;
         sel_nxt      = (sel == PW'(N_DIGITS - 1)) ? '0 : sel + PW'(1);
      end
   end

   // Outputs are built from next-state values so digito and seg/dp move on
   // the same edge and a fresh pop is shown as soon as slot 0 is selected.
   assign glyph_nxt = glyph(janela_nxt[sel_nxt].tom, janela_nxt[sel_nxt].notas,
                            janela_nxt[sel_nxt].ocupado);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         janela   <= '0;
         scan_cnt <= '0;
         sel      <= '0;
         digito   <= N_DIGITS'(1);
         seg      <= SEG_VAZIO;
         dp       <= 1'b0;
      end else begin
         janela   <= janela_nxt;
         scan_cnt <= scan_cnt_nxt;
         sel      <= sel_nxt;
         digito   <= N_DIGITS'(1) << sel_nxt;
         seg      <= glyph_nxt[7:1];
         dp       <= glyph_nxt[0];
      end
   end

endmodule

// File: tb/tb_alfa_nota_display.sv
module tb_alfa_nota_display;
   localparam int N     = 4;
   localparam int DEPTH = 4;
   localparam int STEP  = 8;
   localparam int SCAN  = 2;
   localparam logic [6:0] GLYPH_TB [8] = '{7'b1001110, 7'b0111101, 7'b1001111, 7'b1000111,
                                           7'b1111011, 7'b1110111, 7'b0011111, 7'b0000001};

   logic       clk;
   logic       rst_n;
   logic       in_valid;
   logic       in_ready;
   logic       in_tom;
   logic [2:0] in_notas;
   logic       pausa;
   logic       limpar;
   logic [6:0] seg;
   logic       dp;
   logic [3:0] digito;
   logic [2:0] nivel;

   int total = 0;
   int bad   = 0;

   alfa_nota_display #(
      .N_DIGITS    (N),
      .DEPTH       (DEPTH),
      .STEP_CYCLES (STEP),
      .SCAN_DIV    (SCAN)
   ) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .in_valid (in_valid),
      .in_ready (in_ready),
      .in_tom   (in_tom),
      .in_notas (in_notas),
      .pausa    (pausa),
      .limpar   (limpar),
      .seg      (seg),
      .dp       (dp),
      .digito   (digito),
      .nivel    (nivel)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference model: queue for the FIFO, array of codes for the window
   // (-1 = never filled), plain integer counters for tempo and scan.
   int q[$];
   int win[N];
   int m_step;
   int m_pos;
   int m_scnt;
   bit m_acc;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         q.delete();
         for (int i = 0; i < N; i++) win[i] = -1;
         m_step = 0;
         m_pos  = 0;
         m_scnt = 0;
      end else begin
         m_acc = in_valid && (q.size() < DEPTH);
         if (limpar) begin
            q.delete();
            for (int i = 0; i < N; i++) win[i] = -1;
            m_step = 0;
         end else begin
            if (!pausa) begin
               if (m_step == STEP - 1) begin
                  m_step = 0;
                  if (q.size() > 0) begin
                     for (int k = N - 1; k > 0; k--) win[k] = win[k-1];
                     win[0] = q.pop_front();
                  end
               end else begin
                  m_step = m_step + 1;
               end
            end
            if (m_acc) q.push_back({28'd0, in_tom, in_notas});
         end
         m_scnt = m_scnt + 1;
         if (m_scnt == SCAN) begin
            m_scnt = 0;
            m_pos  = (m_pos + 1) % N;
         end
      end
   end

   // {in_ready, nivel, digito, seg, dp} as the model predicts them
   function automatic logic [15:0] m_out();
      logic [6:0] s;
      logic       d;
      int         c;
      c = win[m_pos];
      s = 7'd0;
      d = 1'b0;
      if (c >= 0) begin
         s = GLYPH_TB[c % 8];
         d = (c >= 8) && ((c % 8) != 7);
      end
      return {(q.size() < DEPTH), 3'(q.size()), 4'(1 << m_pos), s, d};
   endfunction

   task automatic test_reset();
      logic [3:0] seq [5];
      seq[0] = 4'b0001; seq[1] = 4'b0010; seq[2] = 4'b0100; seq[3] = 4'b1000; seq[4] = 4'b0001;
      total++;
      if ({in_ready, nivel, digito, seg, dp} !== {1'b1, 3'd0, 4'b0001, 7'd0, 1'b0}) begin
         bad++;
         $display("FAIL reset_values got=%h want=%h", {in_ready, nivel, digito, seg, dp},
                  {1'b1, 3'd0, 4'b0001, 7'd0, 1'b0});
      end
      for (int i = 1; i < 5; i++) begin
         @(negedge clk);
         total++;
         if (digito !== seq[i-1]) begin
            bad++;
            $display("FAIL reset_scan_hold%0d got=%b want=%b", i, digito, seq[i-1]);
         end
         @(negedge clk);
         total++;
         if ({digito, seg, dp} !== {seq[i], 7'd0, 1'b0}) begin
            bad++;
            $display("FAIL reset_scan%0d got=%h want=%h", i, {digito, seg, dp}, {seq[i], 8'd0});
         end
      end
   endtask

   task automatic test_mapping();
      int         order [16];
      int         j;
      int         t;
      int         code;
      logic [7:0] want;
      for (int i = 0; i < 16; i++) order[i] = i;
      for (int i = 15; i > 0; i--) begin
         j = int'($urandom_range(0, i));
         t = order[i]; order[i] = order[j]; order[j] = t;
      end
      for (int i = 0; i < 16; i++) begin
         code = order[i];
         limpar = 1'b1;
         @(negedge clk);
         limpar   = 1'b0;
         in_tom   = code[3];
         in_notas = code[2:0];
         in_valid = 1'b1;
         @(negedge clk);
         in_valid = 1'b0;
         for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            total++;
            if ({in_ready, nivel, digito, seg, dp} !== m_out()) begin
               bad++;
               $display("FAIL map_model code=%0d got=%h want=%h", code,
                        {in_ready, nivel, digito, seg, dp}, m_out());
            end
         end
         for (int w = 0; w < 8 && digito != 4'b0001; w++) @(negedge clk);
         want = {GLYPH_TB[code % 8], (code >= 8) && ((code % 8) != 7)};
         total++;
         if ({digito, seg, dp} !== {4'b0001, want}) begin
            bad++;
            $display("FAIL map_glyph code=%0d got=%h want=%h", code, {digito, seg, dp},
                     {4'b0001, want});
         end
      end
   endtask

   task automatic test_full();
      int w;
      limpar = 1'b1;
      pausa  = 1'b1;
      @(negedge clk);
      limpar   = 1'b0;
      in_valid = 1'b1;
      for (int i = 0; i < 4; i++) begin
         total++;
         if (in_ready !== 1'b1) begin
            bad++;
            $display("FAIL full_ready_before%0d got=%b want=1", i, in_ready);
         end
         in_tom   = 1'($urandom_range(0, 1));
         in_notas = 3'($urandom_range(0, 7));
         @(negedge clk);
      end
      in_tom   = 1'b0;
      in_notas = 3'd5;
      for (int c = 0; c < 3; c++) begin
         total++;
         if ({in_ready, nivel} !== {1'b0, 3'd4} || m_out() !== {in_ready, nivel, digito, seg, dp}) begin
            bad++;
            $display("FAIL full_hold got=%h want=%h", {in_ready, nivel, digito, seg, dp}, m_out());
         end
         @(negedge clk);
      end
      pausa = 1'b0;
      w = 0;
      while (nivel == 3'd4 && w < 12) begin
         @(negedge clk);
         w++;
      end
      total++;
      if ({in_ready, nivel} !== {1'b1, 3'd3}) begin
         bad++;
         $display("FAIL full_after_step got=%h want=%h waited=%0d", {in_ready, nivel}, {1'b1, 3'd3}, w);
      end
      @(negedge clk);
      in_valid = 1'b0;
      total++;
      if ({in_ready, nivel, digito, seg, dp} !== m_out() || nivel !== 3'd4) begin
         bad++;
         $display("FAIL full_fifth_accept got=%h want=%h", {in_ready, nivel, digito, seg, dp}, m_out());
      end
   endtask

   task automatic test_scroll();
      int         notes [5];
      int         w;
      logic [7:0] want [4];
      notes[0] = 0; notes[1] = 2; notes[2] = 4; notes[3] = 13; notes[4] = 6;
      want[0] = {7'b0011111, 1'b0};
      want[1] = {7'b1110111, 1'b1};
      want[2] = {7'b1111011, 1'b0};
      want[3] = {7'b1001111, 1'b0};
      pausa  = 1'b0;
      limpar = 1'b1;
      @(negedge clk);
      limpar = 1'b0;
      for (int i = 0; i < 5; i++) begin
         in_valid = 1'b1;
         in_tom   = notes[i][3];
         in_notas = notes[i][2:0];
         w = 0;
         while (!in_ready && w < 20) begin
            @(negedge clk);
            w++;
         end
         @(negedge clk);
         total++;
         if (w >= 20 || {in_ready, nivel, digito, seg, dp} !== m_out()) begin
            bad++;
            $display("FAIL scroll_push%0d got=%h want=%h waited=%0d", i,
                     {in_ready, nivel, digito, seg, dp}, m_out(), w);
         end
      end
      in_valid = 1'b0;
      w = 0;
      while (nivel != 3'd0 && w < 60) begin
         @(negedge clk);
         w++;
      end
      total++;
      if (nivel !== 3'd0) begin
         bad++;
         $display("FAIL scroll_drain got=%0d want=0", nivel);
      end
      for (int p = 0; p < 4; p++) begin
         for (int c = 0; c < 8 && digito != 4'(1 << p); c++) @(negedge clk);
         total++;
         if ({digito, seg, dp} !== {4'(1 << p), want[p]}) begin
            bad++;
            $display("FAIL scroll_slot%0d got=%h want=%h", p, {digito, seg, dp}, {4'(1 << p), want[p]});
         end
      end
   endtask

   task automatic test_pause();
      int held;
      int w;
      pausa  = 1'b0;
      limpar = 1'b1;
      @(negedge clk);
      limpar = 1'b0;
      repeat ($urandom_range(0, 7)) @(negedge clk);
      pausa    = 1'b1;
      in_valid = 1'b1;
      in_tom   = 1'b1;
      in_notas = 3'd1;
      @(negedge clk);
      in_notas = 3'd3;
      @(negedge clk);
      in_valid = 1'b0;
      for (int c = 0; c < 24; c++) begin
         @(negedge clk);
         total++;
         if (nivel !== 3'd2 || {in_ready, nivel, digito, seg, dp} !== m_out()) begin
            bad++;
            $display("FAIL pause_hold c=%0d got=%h want=%h", c, {in_ready, nivel, digito, seg, dp}, m_out());
         end
      end
      held  = m_step;
      pausa = 1'b0;
      w = 0;
      while (nivel == 3'd2 && w < 20) begin
         @(negedge clk);
         w++;
      end
      total++;
      if (w !== STEP - held || nivel !== 3'd1) begin
         bad++;
         $display("FAIL pause_resume got=%0d cycles want=%0d (held=%0d)", w, STEP - held, held);
      end
   endtask

   task automatic test_clear();
      pausa    = 1'b1;
      in_valid = 1'b1;
      in_tom   = 1'b0;
      in_notas = 3'd0;
      @(negedge clk);
      in_notas = 3'd6;
      @(negedge clk);
      total++;
      if (nivel !== 3'd3) begin
         bad++;
         $display("FAIL clear_setup got=%0d want=3", nivel);
      end
      limpar   = 1'b1;
      in_notas = 3'd2;
      @(negedge clk);
      limpar   = 1'b0;
      in_valid = 1'b0;
      total++;
      if ({in_ready, nivel, seg, dp} !== {1'b1, 3'd0, 7'd0, 1'b0}) begin
         bad++;
         $display("FAIL clear_now got=%h want=%h", {in_ready, nivel, seg, dp}, {1'b1, 3'd0, 8'd0});
      end
      for (int c = 0; c < 8; c++) begin
         @(negedge clk);
         total++;
         if ({in_ready, nivel, seg, dp} !== {1'b1, 3'd0, 7'd0, 1'b0}) begin
            bad++;
            $display("FAIL clear_blank c=%0d got=%h want=%h", c, {in_ready, nivel, seg, dp},
                     {1'b1, 3'd0, 8'd0});
         end
      end
      pausa = 1'b0;
   endtask

   task automatic test_random();
      for (int c = 0; c < 400; c++) begin
         in_valid = 1'($urandom_range(0, 1));
         in_tom   = 1'($urandom_range(0, 1));
         in_notas = 3'($urandom_range(0, 7));
         pausa    = ($urandom_range(0, 3) == 0);
         limpar   = ($urandom_range(0, 39) == 0);
         @(negedge clk);
         total++;
         if ({in_ready, nivel, digito, seg, dp} !== m_out()) begin
            bad++;
            $display("FAIL random c=%0d got=%h want=%h", c, {in_ready, nivel, digito, seg, dp}, m_out());
         end
      end
   endtask

   task automatic test_reset_mid();
      for (int r = 0; r < 3; r++) begin
         repeat ($urandom_range(5, 30)) begin
            in_valid = 1'($urandom_range(0, 1));
            in_tom   = 1'($urandom_range(0, 1));
            in_notas = 3'($urandom_range(0, 7));
            pausa    = 1'b0;
            limpar   = 1'b0;
            @(negedge clk);
         end
         #2;
         rst_n = 1'b0;
         #1;
         total++;
         if ({in_ready, nivel, digito, seg, dp} !== {1'b1, 3'd0, 4'b0001, 7'd0, 1'b0}) begin
            bad++;
            $display("FAIL reset_mid%0d got=%h want=%h", r, {in_ready, nivel, digito, seg, dp},
                     {1'b1, 3'd0, 4'b0001, 8'd0});
         end
         in_valid = 1'b0;
         @(negedge clk);
         rst_n = 1'b1;
         repeat (3) @(negedge clk);
         total++;
         if ({in_ready, nivel, digito, seg, dp} !== m_out()) begin
            bad++;
            $display("FAIL reset_mid_after%0d got=%h want=%h", r, {in_ready, nivel, digito, seg, dp}, m_out());
         end
      end
   endtask

   initial begin
      rst_n    = 1'b0;
      in_valid = 1'b0;
      in_tom   = 1'b0;
      in_notas = 3'd0;
      pausa    = 1'b0;
      limpar   = 1'b0;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      test_reset();
      test_mapping();
      test_full();
      test_scroll();
      test_pause();
      test_clear();
      test_random();
      test_reset_mid();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
